// File: rtl/overlay_text_ctrl_if.sv
// overlay_text_ctrl_if: shared font ROM port; the controller drives the address,
// the ROM returns the glyph row one Clk later.
interface overlay_text_ctrl_if;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    modport master (output font_addr, input font_data);
    modport slave  (input font_addr, output font_data);
endinterface

// File: rtl/overlay_text_ctrl.sv
// overlay_text_ctrl: game-phase FSM plus screen-message font addressing and pixel flag.
// Define OVERLAY_BLINK_EN to blink the START/PAUSE messages; otherwise all messages are solid.
module overlay_text_ctrl #(
    parameter logic [9:0] TEXT_Y       = 10'd231,
    parameter int         HOLD_FRAMES  = 60,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       frame_start,
    input  logic                       start_key,
    input  logic                       pause_key,
    input  logic                       player_dead,
    input  logic                       level_won,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    overlay_text_ctrl_if.master        font,
    output logic                       overlay_on,
    output logic [2:0]                 msg_id,
    output logic                       game_run,
    output logic                       game_reset
);
    typedef enum logic [2:0] {S_START, S_RUN, S_PAUSE, S_OVER, S_WIN} state_t;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    // Glyph codes, index 0 is the leftmost character; unused slots pad with blank.
    localparam logic [0:8][6:0] TXT_START = {7'h17, 7'h18, 7'h0C, 7'h16, 7'h18, 7'h0A, 7'h00, 7'h00, 7'h00};
    localparam logic [0:8][6:0] TXT_PAUSE = {7'h15, 7'h0C, 7'h19, 7'h17, 7'h0E, 7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [0:8][6:0] TXT_OVER  = {7'h0F, 7'h0C, 7'h12, 7'h0E, 7'h00, 7'h14, 7'h1A, 7'h0E, 7'h16};
    localparam logic [0:8][6:0] TXT_WIN   = {7'h1C, 7'h14, 7'h19, 7'h00, 7'h1B, 7'h10, 7'h13, 7'h0A, 7'h00};

    state_t state, next;
    logic start_q, pause_q, start_edge, pause_edge, hold_full, visible;
    logic [HW-1:0] hold_cnt;
    logic [0:8][6:0] txt;
    logic [3:0] len, idx, dy;
    logic [9:0] x0, x_end;
    logic in_win, in_win_d;
    logic [2:0] col_d;

    assign start_edge = start_key & ~start_q;
    assign pause_edge = pause_key & ~pause_q;
    assign hold_full  = hold_cnt == HW'(HOLD_FRAMES);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_START;
            start_q    <= 1'b0;
            pause_q    <= 1'b0;
            hold_cnt   <= '0;
            game_reset <= 1'b0;
        end else begin
            state      <= next;
            start_q    <= start_key;
            pause_q    <= pause_key;
            hold_cnt   <= (next != state) ? '0 : (frame_start && !hold_full) ? hold_cnt + 1'b1 : hold_cnt;
            game_reset <= (state == S_OVER || state == S_WIN) && next == S_START;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_START:       next = start_edge ? S_RUN : S_START;
            S_RUN:         next = player_dead ? S_OVER : level_won ? S_WIN : pause_edge ? S_PAUSE : S_RUN;
            S_PAUSE:       next = pause_edge ? S_RUN : S_PAUSE;
            S_OVER, S_WIN: next = (start_edge && hold_full) ? S_START : state;
            default:       next = S_START;
        endcase
    end

    always_comb begin
        game_run = state == S_RUN;
        msg_id   = 3'd0;
        len      = 4'd0;
        txt      = '0;
        case (state)
            S_START: begin msg_id = 3'd1; len = 4'd6; txt = TXT_START; end
            S_PAUSE: begin msg_id = 3'd2; len = 4'd5; txt = TXT_PAUSE; end
            S_OVER:  begin msg_id = 3'd3; len = 4'd9; txt = TXT_OVER;  end
            S_WIN:   begin msg_id = 3'd4; len = 4'd8; txt = TXT_WIN;   end
            default: ;
        endcase
    end

    // Centre the message: X0 = 320 - 4*len, width 8*len.
    assign x0     = 10'd320 - {4'd0, len, 2'd0};
    assign x_end  = x0 + {3'd0, len, 3'd0};
    assign idx    = 4'((DrawX - x0) >> 3);
    assign dy     = 4'(DrawY - TEXT_Y);
    assign in_win = len != 4'd0 && DrawY >= TEXT_Y && DrawY < TEXT_Y + 10'd16 && DrawX >= x0 && DrawX < x_end;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            font.font_addr <= '0;
            in_win_d       <= 1'b0;
            col_d          <= '0;
        end else begin
            font.font_addr <= in_win ? {txt[idx], dy} : '0;
            in_win_d       <= in_win;
            col_d          <= DrawX[2:0];
        end
    end

`ifdef OVERLAY_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES);
    logic [BW-1:0] blink_cnt;
    logic blink_on, blink_wrap;
    assign blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (next != state) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
            blink_on  <= blink_wrap ? ~blink_on : blink_on;
        end
    end
    assign visible = blink_on | state == S_OVER | state == S_WIN;
`else
    assign visible = BLINK_FRAMES != 0;
`endif

    assign overlay_on = in_win_d & visible & font.font_data[3'd7 - col_d];
endmodule

// File: tb/tb_overlay_text_ctrl.sv
// tb_overlay_text_ctrl: randomized scoreboard bench; a message-level model predicts
// every output per Clk and a monitor compares after each rising edge.
module tb_overlay_text_ctrl;
`ifdef OVERLAY_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    logic Clk = 1'b0;
    logic Reset, frame_start, start_key, pause_key, player_dead, level_won;
    logic [9:0] DrawX, DrawY;
    logic overlay_on, game_run, game_reset;
    logic [2:0] msg_id;
    overlay_text_ctrl_if font_if();

    overlay_text_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .start_key(start_key),
        .pause_key(pause_key), .player_dead(player_dead), .level_won(level_won),
        .DrawX(DrawX), .DrawY(DrawY), .font(font_if), .overlay_on(overlay_on),
        .msg_id(msg_id), .game_run(game_run), .game_reset(game_reset)
    );

    always #5 Clk = ~Clk;

    typedef struct {int addr; bit ov; int msg; bit run; bit rst;} exp_t;
    exp_t exp_q[$];
    int total = 0, bad = 0;

    // Message texts indexed by msg_id (0 = none).
    int codes [5][9] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{'h17, 'h18, 'h0C, 'h16, 'h18, 'h0A, 0, 0, 0},
        '{'h15, 'h0C, 'h19, 'h17, 'h0E, 0, 0, 0, 0},
        '{'h0F, 'h0C, 'h12, 'h0E, 'h00, 'h14, 'h1A, 'h0E, 'h16},
        '{'h1C, 'h14, 'h19, 'h00, 'h1B, 'h10, 'h13, 'h0A, 0}};
    int lens [5] = '{0, 6, 5, 9, 8};
    int m_msg = 1, m_frames = 0;
    bit m_ps = 0, m_pp = 0;

    task automatic chk(string name, int act, int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, want, want, $time);
        end
    endtask

    function automatic bit text_hit(int m, int x, int y, output int addr);
        int x0 = 320 - 4 * lens[m];
        addr = 0;
        if (lens[m] == 0 || y < 231 || y >= 247 || x < x0 || x >= x0 + 8 * lens[m]) return 0;
        addr = codes[m][(x - x0) / 8] * 16 + (y - 231);
        return 1;
    endfunction

    task automatic tick();
        exp_t e;
        int a, nm;
        bit w, se, pe, vis;
        if (!Reset) begin
            m_msg = 1; m_frames = 0; m_ps = 0; m_pp = 0;
            e = '{0, 0, 1, 0, 0};
        end else begin
            w  = text_hit(m_msg, int'(DrawX), int'(DrawY), a);
            se = start_key && !m_ps;
            pe = pause_key && !m_pp;
            nm = m_msg;
            if (m_msg == 1 && se) nm = 0;
            else if (m_msg == 0) nm = player_dead ? 3 : level_won ? 4 : pe ? 2 : 0;
            else if (m_msg == 2 && pe) nm = 0;
            else if (m_msg >= 3 && se && m_frames >= 60) nm = 1;
            e.rst = m_msg >= 3 && nm == 1;
            if (nm != m_msg) m_frames = 0;
            else if (frame_start) m_frames++;
            m_msg = nm;
            vis = !BLINK || m_msg >= 3 || (m_frames / 30) % 2 == 0;
            e.addr = w ? a : 0;
            e.ov = w && vis && font_if.font_data[7 - int'(DrawX) % 8];
            e.msg = m_msg;
            e.run = m_msg == 0;
            m_ps = start_key;
            m_pp = pause_key;
        end
        exp_q.push_back(e);
        @(negedge Clk);
    endtask

    task automatic rand_pix();
        DrawX = 10'(280 + $urandom_range(0, 89));
        DrawY = 10'(226 + $urandom_range(0, 25));
        font_if.font_data = 8'($urandom);
    endtask

    task automatic frames(int n, bit rnd);
        repeat (n) begin
            if (rnd) rand_pix();
            frame_start = 1; tick();
            frame_start = 0; tick();
        end
    endtask

    task automatic press_start();
        start_key = 1; tick();
        start_key = 0; tick();
    endtask

    task automatic press_pause();
        pause_key = 1; tick();
        pause_key = 0; tick();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("font_addr", int'(font_if.font_addr), e.addr);
                chk("overlay_on", int'(overlay_on), int'(e.ov));
                chk("msg_id", int'(msg_id), e.msg);
                chk("game_run", int'(game_run), int'(e.run));
                chk("game_reset", int'(game_reset), int'(e.rst));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 0; frame_start = 0; start_key = 0; pause_key = 0; player_dead = 0; level_won = 0;
        DrawX = 10'd296; DrawY = 10'd231; font_if.font_data = 8'hFF;
        @(negedge Clk);
        repeat (3) tick();
        Reset = 1; tick();
        DrawX = 10'd297; tick();
        repeat (40) begin rand_pix(); frame_start = ($urandom_range(0, 7) == 0); tick(); end
        frame_start = 0;
        start_key = 1; repeat (3) begin rand_pix(); tick(); end
        start_key = 0; repeat (20) begin rand_pix(); tick(); end
        pause_key = 1; repeat (3) begin rand_pix(); tick(); end
        pause_key = 0; tick();
        press_pause();
        player_dead = 1; level_won = 1; tick();
        player_dead = 0; level_won = 0; DrawX = 10'd324; DrawY = 10'd240; tick();
        frames(10, 1); press_start();
        frames(49, 1); press_start();
        frames(1, 1);  press_start();
        repeat (4) begin rand_pix(); tick(); end
        press_start();
        level_won = 1; tick();
        level_won = 0;
        frames(60, 1); press_start();
        press_start();
        press_pause();
        press_start();
        font_if.font_data = 8'h80; DrawY = 10'd235;
        DrawX = 10'd300; tick();
        DrawX = 10'd301; tick();
        DrawX = 10'd300;
        frames(35, 0);
        press_pause();
        repeat (5) begin rand_pix(); tick(); end
        Reset = 0;
        #1;
        chk("async_msg_id", int'(msg_id), 1);
        chk("async_game_run", int'(game_run), 0);
        chk("async_overlay_on", int'(overlay_on), 0);
        DrawX = 10'd300; DrawY = 10'd235; font_if.font_data = 8'hFF;
        tick(); tick();
        Reset = 1;
        repeat (400) begin
            rand_pix();
            frame_start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) start_key = ~start_key;
            if ($urandom_range(0, 15) == 0) pause_key = ~pause_key;
            player_dead = ($urandom_range(0, 59) == 0);
            level_won = ($urandom_range(0, 49) == 0);
            tick();
        end
        frame_start = 0; player_dead = 0; level_won = 0;
        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/overlay_text_ctrl.md
Name: overlay_text_ctrl

Overview:
- Sequences the game's screen-message overlay (START!, PAUSE, GAME OVER, YOU WIN!) from a 5-state game-phase FSM.
- Generates font ROM addresses for the active message from DrawX/DrawY and produces a per-pixel foreground flag, aligned to the ROM's 1-cycle read latency.
- Sits between the key/game-event logic, the shared font ROM and the colour mapper.
- Also gates gameplay: `game_run` and a one-cycle `game_reset` pulse.

Parameters:
- TEXT_Y, 231: top row of the 16-row text band.
- HOLD_FRAMES, 60: frames GAME OVER / YOU WIN must be shown before start_key is accepted.
- BLINK_FRAMES, 30: frames per blink half-period (START and PAUSE only).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-Clk pulse at the start of each frame.
- start_key  in  1  level, synchronous to Clk.
- pause_key  in  1  level, synchronous to Clk.
- player_dead  in  1  level.
- level_won  in  1  level.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- font_data  in  8  font ROM row data, valid 1 Clk after font_addr.
- font_addr  out  11  font ROM address.
- overlay_on  out  1  current (delayed) pixel is message foreground.
- msg_id  out  3  displayed message: 0 none, 1 START, 2 PAUSE, 3 OVER, 4 WIN.
- game_run  out  1  gameplay enabled.
- game_reset  out  1  one-Clk pulse to reinitialise the game.

Behaviour:

Reset values (Reset low):
- State S_START; frame/blink counters 0; key-edge registers 0.
- font_addr 0, overlay_on 0, msg_id 1, game_run 0, game_reset 0.

Key edges:
- start_key and pause_key are edge-detected; only a 0->1 transition (previous-cycle register) is an event.
- Holding a key produces one event.

FSM transitions (registered, evaluated every Clk):
- S_START: start edge -> S_RUN.
- S_RUN: player_dead -> S_OVER; else level_won -> S_WIN; else pause edge -> S_PAUSE. player_dead has priority over level_won; both have priority over pause.
- S_PAUSE: pause edge -> S_RUN. start edge, player_dead and level_won are ignored.
- S_OVER / S_WIN: on entry, clear hold_cnt. hold_cnt increments on frame_start and saturates at HOLD_FRAMES. A start edge with hold_cnt == HOLD_FRAMES -> S_START and asserts game_reset for exactly 1 Clk. Earlier start edges are dropped, not queued.

Outputs per state:
- game_run = 1 only in S_RUN.
- msg_id: 0 in S_RUN, otherwise per state.

Text geometry:
- 8-px glyphs, 16 rows, horizontally centred: X0 = 320 - 4*len.
- START! : X0 = 296, 6 chars, codes 17 18 0C 16 18 0A.
- PAUSE : X0 = 300, 5 chars, codes 15 0C 19 17 0E.
- GAME OVER : X0 = 284, 9 chars, codes 0F 0C 12 0E 00 14 1A 0E 16.
- YOU WIN! : X0 = 288, 8 chars, codes 1C 14 19 00 1B 10 13 0A.
- Code 00 is the blank glyph.

Address generation (combinational, registered into font_addr):
- In-window when TEXT_Y <= DrawY < TEXT_Y+16 and X0 <= DrawX < X0 + 8*len.
- In-window: font_addr = code*16 + (DrawY - TEXT_Y)[3:0], char index = (DrawX - X0) >> 3.
- Out-of-window or S_RUN: font_addr = 0.

Pixel output:
- The in-window flag and DrawX[2:0] are delayed 1 Clk to align with font_data.
- overlay_on = in_window_d & visible & font_data[7 - col_d].
- Total latency DrawX/DrawY -> overlay_on: 1 Clk.

Blink:
- blink_cnt counts frame_start pulses and wraps at BLINK_FRAMES - 1, toggling `visible`.
- visible is forced to 1 in S_OVER and S_WIN.
- On any state change: counter = 0, visible = 1.

Reset mid-frame:
- Outputs go to reset values immediately (asynchronous).
- The pipeline flag clears, so no stale pixel is emitted after Reset deasserts.

Optional Feature:
- OVERLAY_BLINK_EN defined: blink as described for S_START and S_PAUSE.
- Not defined: visible is tied to 1 and blink_cnt logic is removed; all messages are solid.
- FSM, timing and latency are identical in both builds.

Test Plan:
- Reset low mid-line, then release:
  - Expect msg_id=1, game_run=0, overlay_on=0.
  - DrawX=296, DrawY=231 -> font_addr=0x170 next Clk.
- In S_START, pulse start_key for 3 Clk -> single transition to S_RUN, game_run=1, msg_id=0, font_addr=0 for all pixels.
- In S_RUN, assert player_dead and level_won in the same Clk -> S_OVER (msg_id=3); DrawX=324, DrawY=240 -> font_addr=0x149.
- In S_OVER, start edge after 10 frames -> ignored. Start edge after 60 frames -> S_START, game_reset high exactly 1 Clk.
- In S_RUN, pause edge -> S_PAUSE:
  - A start edge there is ignored.
  - With OVERLAY_BLINK_EN, overlay_on is suppressed during frames 30-59 after entry.
  - A second pause edge -> S_RUN.
- Pixel alignment: drive font_data=0x80 and DrawX=300 (col 0), then 301 (col 1) in S_PAUSE visible phase -> overlay_on=1 then 0, each 1 Clk after its DrawX.
